tlc_lamp_safety_monitor: RTL and testbench

- Sits directly downstream of traffic_light_controller.
- Consumes the four 3-bit light codes light_m1..light_m4 and drives the field lamp outputs.
- Checks the codes every cycle for illegal codes, conflicting greens, illegal sequences and short yellows.
- On any violation it latches a fault and forces all approaches to flashing red until an operator clear.

---
 rtl/tlc_pkg.sv | 30 +++
 rtl/tlc_approach_checker.sv | 55 +++++
 rtl/tlc_lamp_safety_monitor.sv | 187 ++++++++++++++++++
 tb/tb_tlc_lamp_safety_monitor.sv | 267 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/tlc_pkg.sv
// Shared light encodings, monitor states and fault cause codes for the lamp safety monitor.
// No logic; constants, types and one helper only.
// Not applicable (package).
package tlc_pkg;

  // One-hot {red,yellow,green}; all-zero is a dark lamp (flash off phase)
  localparam logic [2:0] LIGHT_R   = 3'b100;
  localparam logic [2:0] LIGHT_Y   = 3'b010;
  localparam logic [2:0] LIGHT_G   = 3'b001;
  localparam logic [2:0] LIGHT_OFF = 3'b000;

  typedef enum logic [1:0] {
    RECOVER = 2'd0,
    NORMAL  = 2'd1,
    FLASH   = 2'd2
  } mon_state_t;

  // First-fault cause; a lower value wins when causes coincide
  localparam logic [2:0] FC_NONE     = 3'd0;
  localparam logic [2:0] FC_ILLEGAL  = 3'd1;
  localparam logic [2:0] FC_CONFLICT = 3'd2;
  localparam logic [2:0] FC_TRANS    = 3'd3;
  localparam logic [2:0] FC_SHORT_Y  = 3'd4;
  localparam logic [2:0] FC_WDOG     = 3'd5;

  function automatic logic is_legal_code(input logic [2:0] c);
    return (c == LIGHT_R) || (c == LIGHT_Y) || (c == LIGHT_G);
  endfunction

endpackage

// File: rtl/tlc_approach_checker.sv
// Per-approach checker: holds previous code and yellow run length, flags code/sequence faults.
// Flags are combinational on the current input against registered history (zero cycles).
// No backpressure; history updates every cycle. Optional port 'changed' exists only with TLC_MON_WATCHDOG_EN.
module tlc_approach_checker
  import tlc_pkg::*;
#(
  parameter int MIN_YELLOW_CYC = 3
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [2:0] light,
`ifdef TLC_MON_WATCHDOG_EN
  output logic       changed,
`endif
  output logic       ill_code,
  output logic       ill_trans,
  output logic       short_yel,
  output logic       non_red
);

  localparam int YW = $clog2(MIN_YELLOW_CYC + 1);
  localparam logic [YW-1:0] YSAT = YW'(MIN_YELLOW_CYC);

  logic [2:0]    prev;
  logic [YW-1:0] ycnt;

  // History: last sampled code and saturating count of consecutive yellow samples
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      prev <= LIGHT_R;
      ycnt <= '0;
    end else begin
      prev <= light;
      if (light == LIGHT_Y) begin
        if (ycnt != YSAT) ycnt <= ycnt + 1'b1;
      end else begin
        ycnt <= '0;
      end
    end
  end

  // Fault flags for the current sample relative to the stored history
  always_comb begin
    ill_code  = !is_legal_code(light);
    ill_trans = ((prev == LIGHT_G) && (light == LIGHT_R)) ||
                ((prev == LIGHT_R) && (light == LIGHT_Y)) ||
                ((prev == LIGHT_Y) && (light == LIGHT_G));
    short_yel = (prev == LIGHT_Y) && (light == LIGHT_R) && (ycnt < YSAT);
    non_red   = (light != LIGHT_R);
`ifdef TLC_MON_WATCHDOG_EN
    changed   = (light != prev);
`endif
  end

endmodule

// File: rtl/tlc_lamp_safety_monitor.sv
// Lamp safety monitor: passes controller light codes to field lamps, latches first fault and flashes red.
// Lamps follow inputs with 1-cycle latency in NORMAL; a faulty pattern is replaced by all-red on that edge.
// No backpressure; optional stuck-input watchdog (fault code 5) built only with TLC_MON_WATCHDOG_EN.
module tlc_lamp_safety_monitor
  import tlc_pkg::*;
#(
  parameter int         MIN_YELLOW_CYC = 3,
  parameter int         FLASH_HALF     = 4,
  parameter int         ALL_RED_CYC    = 2,
  parameter logic [5:0] GREEN_COMPAT   = 6'b000001,
  parameter int         WDOG_CYC       = 1024
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [2:0] light_m1,
  input  logic [2:0] light_m2,
  input  logic [2:0] light_m3,
  input  logic [2:0] light_m4,
  input  logic       fault_clr,
  output logic [2:0] lamp_m1,
  output logic [2:0] lamp_m2,
  output logic [2:0] lamp_m3,
  output logic [2:0] lamp_m4,
  output logic       fault,
  output logic [2:0] fault_code,
  output logic       flash_active
);

  localparam int ARW = $clog2(ALL_RED_CYC + 1);
  localparam int FLW = $clog2(FLASH_HALF + 1);
  localparam logic [ARW-1:0] AR_LAST = ARW'(ALL_RED_CYC - 1);
  localparam logic [FLW-1:0] FL_LAST = FLW'(FLASH_HALF - 1);

  logic [3:0][2:0] light_v;
  logic [3:0]      ill_code, ill_trans, short_yel, non_red;
  logic            conflict, all_red_in, wdog_hit;
  logic [2:0]      cause;

  mon_state_t      state, state_nxt;
  logic [3:0][2:0] lamps_q, lamps_nxt;
  logic            fault_q, fault_nxt;
  logic [2:0]      code_q, code_nxt;
  logic [ARW-1:0]  ar_cnt, ar_nxt;
  logic [FLW-1:0]  fl_cnt, fl_nxt;
  logic            fl_off, fl_off_nxt;

  assign light_v    = {light_m4, light_m3, light_m2, light_m1};
  assign all_red_in = (light_v == {4{LIGHT_R}});

`ifdef TLC_MON_WATCHDOG_EN
  localparam int WW = $clog2(WDOG_CYC + 1);
  logic [3:0]    changed;
  logic [WW-1:0] wd_cnt;
`endif

  for (genvar g = 0; g < 4; g++) begin : g_chk
    tlc_approach_checker #(.MIN_YELLOW_CYC(MIN_YELLOW_CYC)) u_chk (
      .clk       (clk),
      .reset     (reset),
      .light     (light_v[g]),
`ifdef TLC_MON_WATCHDOG_EN
      .changed   (changed[g]),
`endif
      .ill_code  (ill_code[g]),
      .ill_trans (ill_trans[g]),
      .short_yel (short_yel[g]),
      .non_red   (non_red[g])
    );
  end

`ifdef TLC_MON_WATCHDOG_EN
  // Stable-input timer; only meaningful in NORMAL, so it is held at zero elsewhere
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wd_cnt <= '0;
    end else if ((|changed) || (state != NORMAL)) begin
      wd_cnt <= '0;
    end else if (wd_cnt != WW'(WDOG_CYC)) begin
      wd_cnt <= wd_cnt + 1'b1;
    end
  end
  assign wdog_hit = (state == NORMAL) && (wd_cnt == WW'(WDOG_CYC));
`else
  assign wdog_hit = 1'b0;
`endif

  // Pairwise conflict: two non-red approaches whose compatibility bit is clear, then priority encode
  always_comb begin
    conflict = (non_red[0] && non_red[1] && !GREEN_COMPAT[0]) ||
               (non_red[0] && non_red[2] && !GREEN_COMPAT[1]) ||
               (non_red[0] && non_red[3] && !GREEN_COMPAT[2]) ||
               (non_red[1] && non_red[2] && !GREEN_COMPAT[3]) ||
               (non_red[1] && non_red[3] && !GREEN_COMPAT[4]) ||
               (non_red[2] && non_red[3] && !GREEN_COMPAT[5]);
    cause = FC_NONE;
    if (|ill_code)       cause = FC_ILLEGAL;
    else if (conflict)   cause = FC_CONFLICT;
    else if (|ill_trans) cause = FC_TRANS;
    else if (|short_yel) cause = FC_SHORT_Y;
    else if (wdog_hit)   cause = FC_WDOG;
  end

  // State and registered outputs
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state   <= RECOVER;
      lamps_q <= {4{LIGHT_R}};
      fault_q <= 1'b0;
      code_q  <= FC_NONE;
      ar_cnt  <= '0;
      fl_cnt  <= '0;
      fl_off  <= 1'b0;
    end else begin
      state   <= state_nxt;
      lamps_q <= lamps_nxt;
      fault_q <= fault_nxt;
      code_q  <= code_nxt;
      ar_cnt  <= ar_nxt;
      fl_cnt  <= fl_nxt;
      fl_off  <= fl_off_nxt;
    end
  end

  // Next state and next lamp/fault values; fault_code only changes on FLASH entry or clear
  always_comb begin
    state_nxt  = state;
    lamps_nxt  = lamps_q;
    fault_nxt  = fault_q;
    code_nxt   = code_q;
    ar_nxt     = ar_cnt;
    fl_nxt     = fl_cnt;
    fl_off_nxt = fl_off;
    case (state)
      RECOVER: begin
        lamps_nxt = {4{LIGHT_R}};
        if (ar_cnt == AR_LAST) begin
          state_nxt = NORMAL;
          ar_nxt    = '0;
        end else begin
          ar_nxt = ar_cnt + 1'b1;
        end
      end
      NORMAL: begin
        if (cause != FC_NONE) begin
          state_nxt  = FLASH;
          lamps_nxt  = {4{LIGHT_R}};
          fault_nxt  = 1'b1;
          code_nxt   = cause;
          fl_nxt     = '0;
          fl_off_nxt = 1'b0;
        end else begin
          lamps_nxt = light_v;
        end
      end
      FLASH: begin
        if (fault_clr && all_red_in) begin
          state_nxt = RECOVER;
          lamps_nxt = {4{LIGHT_R}};
          fault_nxt = 1'b0;
          code_nxt  = FC_NONE;
          ar_nxt    = '0;
        end else if (fl_cnt == FL_LAST) begin
          fl_nxt     = '0;
          fl_off_nxt = !fl_off;
          lamps_nxt  = fl_off ? {4{LIGHT_R}} : {4{LIGHT_OFF}};
        end else begin
          fl_nxt    = fl_cnt + 1'b1;
          lamps_nxt = fl_off ? {4{LIGHT_OFF}} : {4{LIGHT_R}};
        end
      end
      default: begin
        state_nxt = RECOVER;
        lamps_nxt = {4{LIGHT_R}};
        ar_nxt    = '0;
      end
    endcase
  end

  assign lamp_m1      = lamps_q[0];
  assign lamp_m2      = lamps_q[1];
  assign lamp_m3      = lamps_q[2];
  assign lamp_m4      = lamps_q[3];
  assign fault        = fault_q;
  assign fault_code   = code_q;
  assign flash_active = (state == FLASH);

endmodule

// File: tb/tb_tlc_lamp_safety_monitor.sv
module tb_tlc_lamp_safety_monitor;

  localparam int         MIN_Y  = 3;
  localparam int         FH     = 4;
  localparam int         ARC    = 2;
  localparam logic [5:0] COMPAT = 6'b000001;
  localparam logic [2:0] R   = 3'b100;
  localparam logic [2:0] Y   = 3'b010;
  localparam logic [2:0] G   = 3'b001;
  localparam logic [2:0] OFF = 3'b000;

  logic       clk = 1'b0;
  logic       reset;
  logic [2:0] l1, l2, l3, l4;
  logic       clr;
  logic [2:0] lamp_m1, lamp_m2, lamp_m3, lamp_m4;
  logic       fault;
  logic [2:0] fault_code;
  logic       flash_active;

  int vectors = 0;
  int miscompares = 0;

  always #5 clk = ~clk;

  tlc_lamp_safety_monitor dut (
    .clk          (clk),
    .reset        (reset),
    .light_m1     (l1),
    .light_m2     (l2),
    .light_m3     (l3),
    .light_m4     (l4),
    .fault_clr    (clr),
    .lamp_m1      (lamp_m1),
    .lamp_m2      (lamp_m2),
    .lamp_m3      (lamp_m3),
    .lamp_m4      (lamp_m4),
    .fault        (fault),
    .fault_code   (fault_code),
    .flash_active (flash_active)
  );

  // ---------------- behavioural model ----------------
  // mode: 0 all-red recovery, 1 pass-through, 2 fault flash; ticks = cycles spent in mode
  int         m_mode;
  int         m_ticks;
  logic [2:0] m_prev[4];
  int         m_yrun[4];
  logic [2:0] m_lamp[4];
  logic       m_fault;
  logic [2:0] m_code;
  logic [2:0] cur_in[4];
  logic [2:0] m_cv;

  function automatic logic [2:0] m_cause(input logic [2:0] cur[4], input logic [2:0] prv[4],
                                         input int yr[4]);
    bit f1 = 0, f2 = 0, f3 = 0, f4 = 0;
    logic [5:0] cm = COMPAT;
    for (int i = 0; i < 4; i++) begin
      if (!(cur[i] == R || cur[i] == Y || cur[i] == G)) f1 = 1;
      if ((prv[i] == G && cur[i] == R) || (prv[i] == R && cur[i] == Y) ||
          (prv[i] == Y && cur[i] == G)) f3 = 1;
      if (prv[i] == Y && cur[i] == R && yr[i] < MIN_Y) f4 = 1;
    end
    for (int i = 0; i < 3; i++) begin
      for (int j = i + 1; j < 4; j++) begin
        if (cur[i] != R && cur[j] != R && !cm[0]) f2 = 1;
        cm = cm >> 1;
      end
    end
    if (f1) return 3'd1;
    if (f2) return 3'd2;
    if (f3) return 3'd3;
    if (f4) return 3'd4;
    return 3'd0;
  endfunction

  always_comb begin
    cur_in[0] = l1;
    cur_in[1] = l2;
    cur_in[2] = l3;
    cur_in[3] = l4;
  end

  always_comb m_cv = m_cause(cur_in, m_prev, m_yrun);

  always @(posedge clk or negedge reset) begin
    if (!reset) begin
      m_mode  <= 0;
      m_ticks <= 0;
      m_fault <= 1'b0;
      m_code  <= 3'd0;
      for (int i = 0; i < 4; i++) begin
        m_prev[i] <= R;
        m_yrun[i] <= 0;
        m_lamp[i] <= R;
      end
    end else begin
      case (m_mode)
        0: begin
          for (int i = 0; i < 4; i++) m_lamp[i] <= R;
          if (m_ticks + 1 >= ARC) begin
            m_mode  <= 1;
            m_ticks <= 0;
          end else begin
            m_ticks <= m_ticks + 1;
          end
        end
        1: begin
          if (m_cv != 3'd0) begin
            for (int i = 0; i < 4; i++) m_lamp[i] <= R;
            m_fault <= 1'b1;
            m_code  <= m_cv;
            m_mode  <= 2;
            m_ticks <= 0;
          end else begin
            for (int i = 0; i < 4; i++) m_lamp[i] <= cur_in[i];
          end
        end
        default: begin
          if (clr && l1 == R && l2 == R && l3 == R && l4 == R) begin
            for (int i = 0; i < 4; i++) m_lamp[i] <= R;
            m_fault <= 1'b0;
            m_code  <= 3'd0;
            m_mode  <= 0;
            m_ticks <= 0;
          end else begin
            m_ticks <= m_ticks + 1;
            for (int i = 0; i < 4; i++)
              m_lamp[i] <= (((m_ticks + 1) / FH) % 2 == 1) ? OFF : R;
          end
        end
      endcase
      for (int i = 0; i < 4; i++) begin
        m_prev[i] <= cur_in[i];
        m_yrun[i] <= (cur_in[i] == Y) ? m_yrun[i] + 1 : 0;
      end
    end
  end

  // ---------------- checking ----------------
  task automatic check(input string name, input logic [2:0] act, input logic [2:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s at %0t: got %b expected %b", name, $time, act, exp);
    end
  endtask

  // Every cycle, away from the active edge
  always @(negedge clk) begin
    check("lamp_m1", lamp_m1, m_lamp[0]);
    check("lamp_m2", lamp_m2, m_lamp[1]);
    check("lamp_m3", lamp_m3, m_lamp[2]);
    check("lamp_m4", lamp_m4, m_lamp[3]);
    check("fault", {2'b00, fault}, {2'b00, m_fault});
    check("fault_code", fault_code, m_code);
    check("flash_active", {2'b00, flash_active}, {2'b00, (m_mode == 2)});
  end

  // ---------------- stimulus ----------------
  task automatic drive(input logic [2:0] a, input logic [2:0] b, input logic [2:0] c,
                       input logic [2:0] d, input logic cl);
    l1 = a; l2 = b; l3 = c; l4 = d; clr = cl;
  endtask

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic clear_fault();
    drive(R, R, R, R, 1'b1);
    step(1);
    clr = 1'b0;
    step(ARC);
  endtask

  initial begin
    reset = 1'b0;
    drive(R, R, R, R, 1'b0);
    step(3);
    check("rst_lamp_m1", lamp_m1, R);
    check("rst_fault", {2'b00, fault}, 3'd0);
    check("rst_flash", {2'b00, flash_active}, 3'd0);
    reset = 1'b1;
    // Test 1: two all-red cycles then pass-through
    step(ARC);
    check("t1_lamp_m1_red", lamp_m1, R);
    l1 = G;
    step(1);
    check("t1_lamp_m1_green", lamp_m1, G);
    check("t1_fault", {2'b00, fault}, 3'd0);
    // Test 2: G x5, Y x3, R
    step(4);
    l1 = Y;
    step(3);
    check("t2_lamp_m1_yellow", lamp_m1, Y);
    l1 = R;
    step(1);
    check("t2_lamp_m1_red", lamp_m1, R);
    check("t2_fault", {2'b00, fault}, 3'd0);
    // Long yellow saturates the counter, still legal
    l1 = G; step(1);
    l1 = Y; step(5);
    l1 = R; step(1);
    check("t2b_fault", {2'b00, fault}, 3'd0);
    // Test 3: 1-3 conflict
    drive(G, R, G, R, 1'b0);
    step(1);
    check("t3_fault", {2'b00, fault}, 3'd1);
    check("t3_code", fault_code, 3'd2);
    check("t3_lamp_m3", lamp_m3, R);
    check("t3_flash", {2'b00, flash_active}, 3'd1);
    drive(R, R, R, R, 1'b0);
    step(4);
    check("t3_dark", lamp_m1, OFF);
    step(5);
    // Test 6a: clear with a non-red input is ignored
    drive(G, R, R, R, 1'b1);
    step(2);
    check("t6_ignored_fault", {2'b00, fault}, 3'd1);
    check("t6_ignored_code", fault_code, 3'd2);
    drive(R, R, R, R, 1'b1);
    step(1);
    check("t6_clr_fault", {2'b00, fault}, 3'd0);
    check("t6_clr_code", fault_code, 3'd0);
    clr = 1'b0;
    step(ARC);
    // Test 4a: short yellow on approach 2
    l2 = G; step(1);
    l2 = Y; step(2);
    l2 = R; step(1);
    check("t4_short_code", fault_code, 3'd4);
    clear_fault();
    // Test 4b: G->R on approach 4
    l4 = G; step(1);
    l4 = R; step(1);
    check("t4_trans_code", fault_code, 3'd3);
    clear_fault();
    // Test 5: illegal code beats simultaneous conflict
    drive(G, R, G, 3'b011, 1'b0);
    step(1);
    check("t5_code", fault_code, 3'd1);
    check("t5_lamp_m4", lamp_m4, R);
    // Test 6b: asynchronous reset mid-flash
    drive(R, R, R, R, 1'b0);
    step(5);
    #2 reset = 1'b0;
    #1;
    check("t6_rst_lamp_m2", lamp_m2, R);
    check("t6_rst_fault", {2'b00, fault}, 3'd0);
    check("t6_rst_flash", {2'b00, flash_active}, 3'd0);
    step(2);
    reset = 1'b1;
    step(ARC);
    l1 = G;
    step(1);
    check("t6_after_rst_m1", lamp_m1, G);
    step(2);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
